// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-unit FSM encoding and default fetch-path constants
// used by IF, decode and the PC unit.
package cpu_pkg;

    // PC unit life cycle: one boot cycle, normal fetch, then a terminal halt
    typedef enum logic [1:0] {
        PCU_BOOT = 2'b00,
        PCU_RUN  = 2'b01,
        PCU_HALT = 2'b10
    } pcu_state_e;

    localparam int          CPU_PC_W      = 16;
    localparam int          CPU_INC       = 2;
    localparam logic [15:0] CPU_RESET_VEC = 16'h0000;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch-side pipeline logic and the PC unit.
// master = pipeline side (issues stall/redirect/halt/RAS ops), slave = PC unit.
interface pc_unit_if
    import cpu_pkg::*;
#(
    parameter int PC_W = CPU_PC_W
);
    logic            stall;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic            halt_req;
    logic            ras_push;
    logic [PC_W-1:0] ras_push_data;
    logic            ras_pop;
    logic [PC_W-1:0] curr_pc;
    logic [PC_W-1:0] pc_plus;
    logic            fetch_valid;
    logic            halted;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_ovf;
    logic            ras_unf;

    modport master (
        output stall, redirect_en, redirect_pc, halt_req,
        output ras_push, ras_push_data, ras_pop,
        input  curr_pc, pc_plus, fetch_valid, halted,
        input  ras_top, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, redirect_en, redirect_pc, halt_req,
        input  ras_push, ras_push_data, ras_pop,
        output curr_pc, pc_plus, fetch_valid, halted,
        output ras_top, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full silently drops the oldest
// entry (the write pointer simply laps it); underflow and overflow are sticky.
module pc_ras
    import cpu_pkg::*;
#(
    parameter int              PC_W      = CPU_PC_W,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(CPU_RESET_VEC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [PC_W-1:0] push_data,
    input  logic            pop,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PTR_W-1:0] wp_reg, wp_next, top_idx, wr_idx;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ovf_reg, ovf_next, unf_reg, unf_next, wr_en;
    logic [RAS_DEPTH-1:0] we_vec;
    logic [PC_W-1:0]  mem_reg [RAS_DEPTH];

    // Top of stack sits just below the write pointer (wraps mod depth)
    assign top_idx = wp_reg - PTR_W'(1);
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_MAX);
    assign top     = empty ? RESET_VEC : mem_reg[top_idx];
    assign ovf     = ovf_reg;
    assign unf     = unf_reg;

    // Push/pop bookkeeping; push+pop on a non-empty stack rewrites the top in place
    always_comb begin
        wp_next    = wp_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        wr_en      = 1'b0;
        wr_idx     = wp_reg;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en   = 1'b1;
            wp_next = wp_reg + PTR_W'(1);
            if (full) begin
                ovf_next = 1'b1;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_next = 1'b1;
            end else begin
                wp_next    = top_idx;
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    // Per-entry write enables decoded from the selected slot
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_we
            assign we_vec[gi] = wr_en && (wr_idx == PTR_W'(gi));
        end
    endgenerate

    // Pointer, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_reg    <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            wp_reg    <= wp_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Entry storage; contents are only observed while count > 0, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (!rst && we_vec[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with boot/run/halt sequencing and an attached RAS.
// Next-PC priority in RUN: redirect > halt (unstalled) > stall > increment.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W      = CPU_PC_W,
    parameter int              INC       = CPU_INC,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(CPU_RESET_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    pc_unit_if.slave bus
);
    pcu_state_e      state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next, pc_plus_w;
    logic            fetch_valid_w, halted_w;

    assign pc_plus_w       = pc_reg + PC_W'(INC);
    assign bus.curr_pc     = pc_reg;
    assign bus.pc_plus     = pc_plus_w;
    assign bus.fetch_valid = fetch_valid_w;
    assign bus.halted      = halted_w;

    // Next-state / next-PC selection; control inputs only matter in RUN
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        fetch_valid_w = 1'b0;
        halted_w      = 1'b0;
        case (state_reg)
            PCU_BOOT: state_next = PCU_RUN;
            PCU_RUN: begin
                fetch_valid_w = 1'b1;
                if (bus.redirect_en) begin
                    // halt_req here belongs to a squashed wrong-path instruction
                    pc_next = bus.redirect_pc;
                end else if (bus.halt_req && !bus.stall) begin
                    state_next = PCU_HALT;
                end else if (!bus.stall) begin
                    pc_next = pc_plus_w;
                end
            end
            PCU_HALT: halted_w = 1'b1;
            default:  state_next = PCU_BOOT;
        endcase
    end

    // PC and FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= PCU_BOOT;
            pc_reg    <= RESET_VEC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_VEC (RESET_VEC)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.ras_push),
        .push_data (bus.ras_push_data),
        .pop       (bus.ras_pop),
        .top       (bus.ras_top),
        .empty     (bus.ras_empty),
        .full      (bus.ras_full),
        .ovf       (bus.ras_ovf),
        .unf       (bus.ras_unf)
    );
endmodule
